queue_reader: RTL and testbench

Consumer-side controller for the 8-deep byte queue. It watches the queue occupancy and issues single-cycle dequeue pulses, then captures each removed byte. Each byte goes downstream over a valid/ready handshake. Draining happens in bursts: a burst starts at an occupancy threshold, or after a flush timeout if a partial fill sits idle. It runs in the 10 kHz domain next to the queue.

---
 rtl/queue_reader.sv | 150 +++++++++++++++
 tb/tb_queue_reader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_reader.sv
// queue_reader: consumer-side controller for the 8-deep byte queue.
// Drains the queue in bursts, starting when occupancy reaches THRESHOLD or
// when a partial fill has sat idle for FLUSH_CYCLES. Each dequeued byte is
// captured and offered downstream over a valid/ready handshake.
module queue_reader #(
   parameter int THRESHOLD    = 4,
   parameter int FLUSH_CYCLES = 200
) (
   input  logic       clk_10khz,
   input  logic       reset,
   input  logic [3:0] len_in,
   input  logic [7:0] data_in,
   output logic       dequeue_out,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] word_count,
   output logic       busy
);

   localparam logic [3:0]  THRESH    = 4'(THRESHOLD);
   localparam logic [15:0] FLUSH_MAX = 16'(FLUSH_CYCLES);
   localparam bit          FLUSH_EN  = (FLUSH_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] flush_cnt;
   logic [15:0] flush_cnt_nxt;

   logic        queue_empty;
   logic        over_thresh;
   logic        partial;
   logic        flush_due;
   logic        start;
   logic        handshake;

   logic [7:0]  data_nxt;
   logic        valid_nxt;
   logic [7:0]  count_nxt;

   // Saturating increment; the flush timer parks at its limit instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value,
                                           input logic [15:0] limit);
      sat_inc = (value >= limit) ? value : value + 16'd1;
   endfunction

   // Decode queue occupancy into burst start conditions.
   always_comb begin
      queue_empty = (len_in == 4'd0);
      over_thresh = (len_in >= THRESH);
      partial     = !queue_empty && !over_thresh;
      flush_due   = FLUSH_EN && !queue_empty && (flush_cnt == FLUSH_MAX);
      // A burst never starts on an empty queue, whatever the parameters.
      start       = !queue_empty && (over_thresh || flush_due);
      handshake   = out_valid && out_ready;
   end

   // Next-state logic and the single-cycle dequeue strobe.
   always_comb begin
      state_nxt   = state;
      dequeue_out = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            dequeue_out = 1'b1;
            state_nxt   = CAPT;
         end
         CAPT: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            // Keep draining while anything is left, including bytes enqueued mid-burst.
            if (handshake) begin
               state_nxt = queue_empty ? IDLE : REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Flush timer counts idle cycles with a partial fill; anything else clears it.
   always_comb begin
      flush_cnt_nxt = 16'd0;
      if ((state == IDLE) && partial) begin
         flush_cnt_nxt = sat_inc(flush_cnt, FLUSH_MAX);
      end
   end

   // Output register updates: capture one cycle after the dequeue, release on handshake.
   always_comb begin
      data_nxt  = out_data;
      valid_nxt = out_valid;
      count_nxt = word_count;
      if (state == CAPT) begin
         data_nxt  = data_in;
         valid_nxt = 1'b1;
      end else if ((state == HOLD) && handshake) begin
         valid_nxt = 1'b0;
         count_nxt = word_count + 8'd1;
      end
   end

   // State and flush timer registers.
   always_ff @(posedge clk_10khz) begin
      if (reset) begin
         state     <= IDLE;
         flush_cnt <= 16'd0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   // Downstream registers; reset drops any byte still held for delivery.
   always_ff @(posedge clk_10khz) begin
      if (reset) begin
         out_data   <= 8'h00;
         out_valid  <= 1'b0;
         word_count <= 8'h00;
      end else begin
         out_data   <= data_nxt;
         out_valid  <= valid_nxt;
         word_count <= count_nxt;
      end
   end

   assign busy = (state != IDLE);

   // Structural invariants of the request/hold sequencing.
   a_no_back_to_back: assert property (@(posedge clk_10khz) disable iff (reset)
      dequeue_out |=> !dequeue_out);
   a_no_dq_while_valid: assert property (@(posedge clk_10khz) disable iff (reset)
      dequeue_out |-> !out_valid);
   a_hold_has_valid: assert property (@(posedge clk_10khz) disable iff (reset)
      (state == HOLD) |-> out_valid);

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader: a small queue model feeds the DUT, a
// negedge monitor logs dequeue times and delivered bytes, and every
// comparison goes through check().
module tb_queue_reader;

   logic       clk;
   logic       reset;
   logic [3:0] len_in;
   logic [7:0] data_in;
   logic       dequeue_out;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] word_count;
   logic       busy;

   logic [3:0] nf_len;
   logic       nf_dq;
   logic [7:0] nf_data;
   logic       nf_valid;
   logic [7:0] nf_wc;
   logic       nf_busy;

   assign nf_len = 4'd2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   queue_reader #(.THRESHOLD(4), .FLUSH_CYCLES(10)) dut (
      .clk_10khz  (clk),
      .reset      (reset),
      .len_in     (len_in),
      .data_in    (data_in),
      .dequeue_out(dequeue_out),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .word_count (word_count),
      .busy       (busy)
   );

   // Second instance with flush disabled, parked on a partial fill of 2.
   queue_reader #(.THRESHOLD(4), .FLUSH_CYCLES(0)) dut_nf (
      .clk_10khz  (clk),
      .reset      (reset),
      .len_in     (nf_len),
      .data_in    (8'h00),
      .dequeue_out(nf_dq),
      .out_data   (nf_data),
      .out_valid  (nf_valid),
      .out_ready  (1'b1),
      .word_count (nf_wc),
      .busy       (nf_busy)
   );

   // Queue model: pops on dequeue, data_out/len_out update at that edge.
   int         enq_n;
   logic [7:0] enq_b [0:7];
   logic [7:0] q [$];

   always @(posedge clk) begin
      if (dequeue_out && (q.size() > 0)) begin
         data_in <= q[0];
         void'(q.pop_front());
      end
      for (int i = 0; i < enq_n; i++) q.push_back(enq_b[i]);
      len_in <= 4'(q.size());
   end

   // Monitor: cycle counter, dequeue log, delivered-byte log.
   int         cyc;
   int         dq_cnt;
   int         hs_cnt;
   int         consec_err;
   int         dqv_err;
   int         nf_dq_cnt;
   int         dq_time [0:1023];
   logic [7:0] hs_dat  [0:1023];
   logic       dq_prev;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (dequeue_out) begin
         if (dq_cnt < 1024) dq_time[dq_cnt] = cyc;
         dq_cnt = dq_cnt + 1;
         if (dq_prev) consec_err = consec_err + 1;
         if (out_valid) dqv_err = dqv_err + 1;
      end
      if (!reset && out_valid && out_ready) begin
         if (hs_cnt < 1024) hs_dat[hs_cnt] = out_data;
         hs_cnt = hs_cnt + 1;
      end
      if (nf_dq) nf_dq_cnt = nf_dq_cnt + 1;
      dq_prev = dequeue_out;
   end

   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic enqueue(input int n, input logic [63:0] bytes);
      for (int i = 0; i < 8; i++) enq_b[i] = bytes[8*i +: 8];
      enq_n = n;
      step(1);
      enq_n = 0;
   endtask

   task automatic wait_for_valid(input int lim);
      int k;
      k = 0;
      while (!out_valid && (k < lim)) begin
         step(1);
         k++;
      end
      check("wait_valid", 32'(out_valid), 1);
   endtask

   task automatic wait_for_dq(input int lim);
      int k;
      k = 0;
      while (!dequeue_out && (k < lim)) begin
         step(1);
         k++;
      end
      check("wait_dq", 32'(dequeue_out), 1);
   endtask

   initial begin
      int         base_dq;
      int         base_hs;
      int         c1;
      logic [63:0] v;

      reset     = 1'b1;
      out_ready = 1'b0;
      enq_n     = 0;
      for (int i = 0; i < 8; i++) enq_b[i] = 8'h00;
      step(3);

      // Reset state
      check("rst_dq",    32'(dequeue_out), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data",  32'(out_data), 0);
      check("rst_wc",    32'(word_count), 0);
      check("rst_busy",  32'(busy), 0);
      reset = 1'b0;
      step(2);

      // Threshold burst
      out_ready = 1'b1;
      base_dq = dq_cnt;
      base_hs = hs_cnt;
      enqueue(4, 64'h00000000_44332211);
      c1 = cyc;
      step(20);
      check("thr_pulses", 32'(dq_cnt - base_dq), 4);
      check("thr_entry",  32'(dq_time[base_dq] - c1), 1);
      for (int i = 1; i < 4; i++)
         check("thr_spacing", 32'(dq_time[base_dq+i] - dq_time[base_dq+i-1]), 3);
      for (int i = 0; i < 4; i++)
         check("thr_data", 32'(hs_dat[base_hs+i]), 32'(8'h11 * (i + 1)));
      check("thr_wc",   32'(word_count), 4);
      check("thr_len",  32'(len_in), 0);
      check("thr_busy", 32'(busy), 0);

      // Backpressure: five stalled cycles on the first byte
      out_ready = 1'b0;
      base_dq = dq_cnt;
      base_hs = hs_cnt;
      enqueue(4, 64'h00000000_88776655);
      wait_for_valid(10);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(out_valid), 1);
         check("bp_data",  32'(out_data), 32'h55);
         check("bp_dq",    32'(dequeue_out), 0);
         step(1);
      end
      out_ready = 1'b1;
      step(25);
      check("bp_pulses", 32'(dq_cnt - base_dq), 4);
      check("bp_span",   32'(dq_time[base_dq+3] - dq_time[base_dq]), 14);
      for (int i = 0; i < 4; i++)
         check("bp_data_seq", 32'(hs_dat[base_hs+i]), 32'(8'h55 + 8'h11 * i));
      check("bp_wc", 32'(word_count), 8);

      // Flush of a partial fill (FLUSH_CYCLES = 10)
      base_dq = dq_cnt;
      base_hs = hs_cnt;
      enqueue(2, 64'h00000000_0000A2A1);
      c1 = cyc;
      step(30);
      check("fl_entry",  32'(dq_time[base_dq] - c1), 11);
      check("fl_pulses", 32'(dq_cnt - base_dq), 2);
      check("fl_data0",  32'(hs_dat[base_hs]), 32'hA1);
      check("fl_data1",  32'(hs_dat[base_hs+1]), 32'hA2);
      check("fl_wc",     32'(word_count), 10);
      check("fl_busy",   32'(busy), 0);

      // Flush disabled: the second instance must never dequeue
      step(1000);
      check("nf_dq",    32'(nf_dq_cnt), 0);
      check("nf_busy",  32'(nf_busy), 0);
      check("nf_valid", 32'(nf_valid), 0);
      check("nf_wc",    32'(nf_wc), 0);

      // Reset in the middle of a burst
      out_ready = 1'b1;
      enqueue(6, 64'h0000B6B5_B4B3B2B1);
      wait_for_dq(10);
      step(1);
      reset = 1'b1;
      step(1);
      check("mr_dq",    32'(dequeue_out), 0);
      check("mr_valid", 32'(out_valid), 0);
      check("mr_data",  32'(out_data), 0);
      check("mr_wc",    32'(word_count), 0);
      check("mr_busy",  32'(busy), 0);
      check("mr_len",   32'(len_in), 5);
      step(1);
      check("mr_dq_hold", 32'(dequeue_out), 0);
      reset = 1'b0;
      base_dq = dq_cnt;
      base_hs = hs_cnt;
      step(1);
      check("mr_resume_dq", 32'(dequeue_out), 1);
      step(25);
      check("mr_pulses", 32'(dq_cnt - base_dq), 5);
      for (int i = 0; i < 5; i++)
         check("mr_data_seq", 32'(hs_dat[base_hs+i]), 32'(8'hB2 + i));
      check("mr_wc", 32'(word_count), 5);

      // Reset while a byte is held
      out_ready = 1'b0;
      enqueue(1, 64'h00000000_000000C1);
      wait_for_valid(20);
      check("mh_data", 32'(out_data), 32'hC1);
      base_hs = hs_cnt;
      reset = 1'b1;
      step(1);
      check("mh_valid", 32'(out_valid), 0);
      check("mh_wc",    32'(word_count), 0);
      check("mh_busy",  32'(busy), 0);
      check("mh_data0", 32'(out_data), 0);
      reset = 1'b0;
      out_ready = 1'b1;
      step(10);
      check("mh_no_deliver", 32'(hs_cnt - base_hs), 0);
      check("mh_wc2",        32'(word_count), 0);
      check("mh_len",        32'(len_in), 0);

      // word_count wrap after 256 deliveries
      for (int k = 0; k < 31; k++) begin
         for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(k * 8 + i);
         enqueue(8, v);
         step(30);
      end
      check("wrap_248", 32'(word_count), 32'hF8);
      for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(248 + i);
      enqueue(7, v);
      step(30);
      check("wrap_ff", 32'(word_count), 32'hFF);
      enqueue(1, 64'h00000000_000000FF);
      step(30);
      check("wrap_00",   32'(word_count), 32'h00);
      check("wrap_last", 32'(hs_dat[hs_cnt-1]), 32'hFF);

      // Global sequencing invariants
      check("dq_consecutive", 32'(consec_err), 0);
      check("dq_with_valid",  32'(dqv_err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
